// File: rtl/bcd_pkg.sv
// Shared BCD constants and a nibble validity helper for the cascaded decade counter.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade: up/down step on carry-in, parallel load, terminal flag for the next stage.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             clear_,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             cin_i,
  output logic [BCD_W-1:0] digit_o,
  output logic [BCD_W-1:0] next_o,
  output logic             term_o
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  // Next digit value: load wins over a carry-in step.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (cin_i) begin
      if (up_i) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clk or negedge clear_) begin
    if (!clear_) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign term_o  = up_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
  assign digit_o = digit_q;
  assign next_o  = digit_d;

endmodule

// File: rtl/bcd_multi_counter.sv
// Cascaded BCD up/down counter with validated load, ripple-carry pulse, sticky match and
// invalid-load flags.
module bcd_multi_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                    clk,
  input  logic                    clear_,
  input  logic                    enable,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] data,
  input  logic [BCD_W*DIGITS-1:0] count_to,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    rco,
  output logic                    done,
  output logic                    err
);

  logic [DIGITS-1:0]       term_s;
  logic [DIGITS-1:0]       cin_s;
  logic [BCD_W*DIGITS-1:0] count_s;
  logic [BCD_W*DIGITS-1:0] count_d;
  logic                    data_ok_s;
  logic                    load_ok_s;
  logic                    at_term_s;
  logic                    step_s;
  logic                    rco_q, rco_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  // Load is accepted only when every data nibble is a decimal digit.
  always_comb begin
    data_ok_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      data_ok_s = data_ok_s & bcd_valid(data[i*BCD_W +: BCD_W]);
    end
  end

  assign load_ok_s = load & data_ok_s;
  assign at_term_s = &term_s;
  // In saturating mode the whole chain is frozen at terminal count.
  assign step_s    = enable & ~load & (WRAP | ~at_term_s);
  assign cin_s[0]  = step_s;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      if (g > 0) begin : g_chain
        assign cin_s[g] = cin_s[g-1] & term_s[g-1];
      end
      bcd_digit u_digit (
        .clk        (clk),
        .clear_     (clear_),
        .up_i       (up),
        .load_i     (load_ok_s),
        .load_val_i (data[g*BCD_W +: BCD_W]),
        .cin_i      (cin_s[g]),
        .digit_o    (count_s[g*BCD_W +: BCD_W]),
        .next_o     (count_d[g*BCD_W +: BCD_W]),
        .term_o     (term_s[g])
      );
    end
  endgenerate

  // Flag next-state; an invalid count_to can never equal a valid count.
  always_comb begin
    rco_d  = enable & ~load & at_term_s;
    err_d  = load & ~data_ok_s;
    done_d = (count_d == count_to) | (done_q & ~load);
  end

  // Flag registers.
  always_ff @(posedge clk or negedge clear_) begin
    if (!clear_) begin
      rco_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      rco_q  <= rco_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign count = count_s;
  assign rco   = rco_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Directed plus random test of a 2-digit counter in wrap and saturate builds against a
// decimal-integer reference model.
module tb_bcd_multi_counter;

  localparam int MAXV = 99;

  logic       clk = 1'b0;
  logic       clear_ = 1'b0;
  logic       enable = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] data = 8'h00, count_to = 8'h00;
  logic [7:0] cnt_w, cnt_s;
  logic       rco_w, rco_s, done_w, done_s, err_w, err_s;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  m_cnt  [2];
  bit  m_rco  [2];
  bit  m_done [2];
  bit  m_err  [2];

  always #5 clk = ~clk;

  bcd_multi_counter #(.DIGITS(2), .WRAP(1'b1)) dut_w (
    .clk(clk), .clear_(clear_), .enable(enable), .up(up), .load(load),
    .data(data), .count_to(count_to), .count(cnt_w), .rco(rco_w), .done(done_w), .err(err_w));

  bcd_multi_counter #(.DIGITS(2), .WRAP(1'b0)) dut_s (
    .clk(clk), .clear_(clear_), .enable(enable), .up(up), .load(load),
    .data(data), .count_to(count_to), .count(cnt_s), .rco(rco_s), .done(done_s), .err(err_s));

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  function automatic int dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count_wrap", cnt_w, to_bcd(m_cnt[0]));
    chk("rco_wrap",   {7'd0, rco_w},  {7'd0, m_rco[0]});
    chk("done_wrap",  {7'd0, done_w}, {7'd0, m_done[0]});
    chk("err_wrap",   {7'd0, err_w},  {7'd0, m_err[0]});
    chk("count_sat",  cnt_s, to_bcd(m_cnt[1]));
    chk("rco_sat",    {7'd0, rco_s},  {7'd0, m_rco[1]});
    chk("done_sat",   {7'd0, done_s}, {7'd0, m_done[1]});
    chk("err_sat",    {7'd0, err_s},  {7'd0, m_err[1]});
  endtask

  task automatic model_clear();
    for (int v = 0; v < 2; v++) begin
      m_cnt[v] = 0; m_rco[v] = 1'b0; m_done[v] = 1'b0; m_err[v] = 1'b0;
    end
  endtask

  // v = 0 wraps at terminal count, v = 1 saturates.
  task automatic model_edge();
    bit term;
    for (int v = 0; v < 2; v++) begin
      m_rco[v] = 1'b0;
      m_err[v] = 1'b0;
      if (load) begin
        if (bcd_ok(data)) m_cnt[v] = dec(data);
        else m_err[v] = 1'b1;
      end else if (enable) begin
        term = up ? (m_cnt[v] == MAXV) : (m_cnt[v] == 0);
        m_rco[v] = term;
        if (term && v == 1) m_cnt[v] = m_cnt[v];
        else if (up) m_cnt[v] = (m_cnt[v] + 1) % (MAXV + 1);
        else m_cnt[v] = (m_cnt[v] + MAXV) % (MAXV + 1);
      end
      m_done[v] = (bcd_ok(count_to) && m_cnt[v] == dec(count_to)) || (m_done[v] && !load);
    end
  endtask

  task automatic step(input logic ld, input logic en, input logic u,
                      input logic [7:0] dat, input logic [7:0] cto);
    load = ld; enable = en; up = u; data = dat; count_to = cto;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse_clear();
    #2 clear_ = 1'b0;
    model_clear();
    #1 check_all();
    #1 clear_ = 1'b1;
  endtask

  initial begin
    model_clear();
    #12 check_all();
    // Inputs are ignored while clear_ is held low.
    load = 1'b1; data = 8'h55; enable = 1'b1;
    @(posedge clk); #1 check_all();
    load = 1'b0; enable = 1'b0;
    @(negedge clk) clear_ = 1'b1;

    // First edge after clear with count_to = 0 sets done.
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h50);

    // Full up count through terminal.
    for (int i = 0; i < 102; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 8'h50);

    // Down from 00: wrap build rolls to 99, saturate build holds with rco high.
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h50);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h50);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h50);

    // Invalid then valid load.
    step(1'b1, 1'b0, 1'b1, 8'h25, 8'h50);
    step(1'b1, 1'b1, 1'b1, 8'h3A, 8'h50);
    step(1'b1, 1'b0, 1'b1, 8'h47, 8'h50);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h50);

    // Sticky done at count_to = 12, cleared by a load.
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'h12);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 8'h00, 8'h12);
    step(1'b1, 1'b0, 1'b1, 8'h05, 8'h12);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'hF3);

    // Clear between edges at 63 with done set, then load+enable on one edge.
    step(1'b1, 1'b0, 1'b1, 8'h63, 8'h63);
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h63);
    pulse_clear();
    step(1'b1, 1'b1, 1'b1, 8'h81, 8'h63);

    // Random traffic with occasional invalid values and mid-run clears.
    for (int i = 0; i < 600; i++) begin
      logic       ld, en, u;
      logic [7:0] dat, cto;
      ld  = ($urandom_range(0, 9) == 0);
      en  = ($urandom_range(0, 3) != 0);
      u   = ($urandom_range(0, 15) < 9);
      dat = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, MAXV));
      cto = ($urandom_range(0, 7) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 20) + 85);
      step(ld, en, u, dat, cto);
      if ($urandom_range(0, 150) == 0) pulse_clear();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
